// File: rtl/mmap_burst_coalescer.sv
// mmap_burst_coalescer
//   Pops beat-aligned byte addresses from an input FIFO and merges contiguous
//   ones into AXI INCR bursts. Each closed burst is pushed as {len, start addr}
//   to the address queue and, when EnableLenOut is set, its len is also pushed
//   to the W-last and B-response queues in the same cycle.
//   A burst never crosses a 2^BoundaryLog-byte boundary. The longest len is
//   clamped at runtime. An idle-wait timeout or flush closes an open burst.
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   max_wait_time               idle cycles tolerated before closing a burst
//   max_burst_len               largest len (beats-1) emitted
//   flush                       close the open burst now
//   addr_dout/addr_empty_n/addr_read          input address FIFO
//   addr_din/addr_full_n/addr_write           {len, addr} output queue
//   burst_len_0_din/_full_n/_write            len to the W-last generator
//   burst_len_1_din/_full_n/_write            len to the write-response tracker
//   busy                        burst open or waiting to be emitted
module mmap_burst_coalescer #(
  parameter int AddrWidth         = 64,
  parameter int DataWidthBytesLog = 6,
  parameter int BurstLenWidth     = 8,
  parameter int WaitTimeWidth     = 4,
  parameter int BoundaryLog       = 12,
  parameter int EnableLenOut      = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [WaitTimeWidth-1:0]           max_wait_time,
  input  logic [BurstLenWidth-1:0]           max_burst_len,
  input  logic                               flush,
  input  logic [AddrWidth-1:0]               addr_dout,
  input  logic                               addr_empty_n,
  output logic                               addr_read,
  output logic [BurstLenWidth+AddrWidth-1:0] addr_din,
  input  logic                               addr_full_n,
  output logic                               addr_write,
  output logic [BurstLenWidth-1:0]           burst_len_0_din,
  input  logic                               burst_len_0_full_n,
  output logic                               burst_len_0_write,
  output logic [BurstLenWidth-1:0]           burst_len_1_din,
  input  logic                               burst_len_1_full_n,
  output logic                               burst_len_1_write,
  output logic                               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  localparam logic [AddrWidth-1:0]     ADDR_ONE = {{(AddrWidth-1){1'b0}}, 1'b1};
  localparam logic [BurstLenWidth-1:0] LEN_ONE  = {{(BurstLenWidth-1){1'b0}}, 1'b1};
  localparam logic [WaitTimeWidth-1:0] WAIT_ONE = {{(WaitTimeWidth-1){1'b0}}, 1'b1};

  state_t                   state_r, state_s;
  logic [AddrWidth-1:0]     start_addr_r, start_addr_s;
  logic [BurstLenWidth-1:0] len_r, len_s;
  logic [WaitTimeWidth-1:0] wait_cnt_r, wait_cnt_s;
  logic [AddrWidth-1:0]     beats_s;
  logic [AddrWidth-1:0]     next_addr_s;
  logic                     ready_out_s;
  logic                     extend_s;
  logic                     pop_s;
  logic                     push_s;

  // Address one beat past the open burst; wraps modulo 2^AddrWidth, so a
  // wrap at all-ones lands on a boundary and stops the burst like any other.
  assign beats_s     = {{(AddrWidth-BurstLenWidth){1'b0}}, len_r} + ADDR_ONE;
  assign next_addr_s = start_addr_r + (beats_s << DataWidthBytesLog);

  // The three queues are pushed together or not at all.
  assign ready_out_s = (EnableLenOut != 0)
                     ? (addr_full_n & burst_len_0_full_n & burst_len_1_full_n)
                     : addr_full_n;

  assign extend_s = (addr_dout == next_addr_s)
                  & (len_r < max_burst_len)
                  & (next_addr_s[BoundaryLog-1:0] != {BoundaryLog{1'b0}})
                  & ~flush;

  // Next-state, pop/push decisions and next register values.
  always_comb begin
    state_s      = state_r;
    start_addr_s = start_addr_r;
    len_s        = len_r;
    wait_cnt_s   = wait_cnt_r;
    pop_s        = 1'b0;
    push_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (addr_empty_n) begin
          pop_s        = 1'b1;
          start_addr_s = addr_dout;
          len_s        = {BurstLenWidth{1'b0}};
          wait_cnt_s   = {WaitTimeWidth{1'b0}};
          state_s      = ACCUM;
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (flush) begin
          state_s = EMIT;
        end else if (addr_empty_n) begin
          if (extend_s) begin
            pop_s      = 1'b1;
            len_s      = len_r + LEN_ONE;
            wait_cnt_s = {WaitTimeWidth{1'b0}};
          end else begin
            // Non-contiguous input stays in the FIFO; it is popped in the push cycle.
            state_s = EMIT;
          end
        end else if (wait_cnt_r == max_wait_time) begin
          state_s = EMIT;
        end else begin
          wait_cnt_s = wait_cnt_r + WAIT_ONE;
        end
      end
      EMIT: begin
        if (ready_out_s) begin
          push_s = 1'b1;
          if (addr_empty_n) begin
            // Start the next burst in the same cycle to keep the stream gapless.
            pop_s        = 1'b1;
            start_addr_s = addr_dout;
            len_s        = {BurstLenWidth{1'b0}};
            wait_cnt_s   = {WaitTimeWidth{1'b0}};
            state_s      = ACCUM;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and burst registers; reset discards any open burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      start_addr_r <= {AddrWidth{1'b0}};
      len_r        <= {BurstLenWidth{1'b0}};
      wait_cnt_r   <= {WaitTimeWidth{1'b0}};
    end else begin
      state_r      <= state_s;
      start_addr_r <= start_addr_s;
      len_r        <= len_s;
      wait_cnt_r   <= wait_cnt_s;
    end
  end

  // Data fields come straight from registers, so they hold steady during a stall.
  assign addr_din          = {len_r, start_addr_r};
  assign burst_len_0_din   = len_r;
  assign burst_len_1_din   = len_r;
  assign addr_write        = push_s;
  assign burst_len_0_write = (EnableLenOut != 0) ? push_s : 1'b0;
  assign burst_len_1_write = (EnableLenOut != 0) ? push_s : 1'b0;
  // IDLE would otherwise pop while reset is held with data present.
  assign addr_read         = pop_s & ~rst;
  assign busy              = (state_r != IDLE);

endmodule

// File: tb/tb_mmap_burst_coalescer.sv
module tb_mmap_burst_coalescer;

  logic        clk;
  logic        rst;
  logic [3:0]  max_wait_time;
  logic [7:0]  max_burst_len;
  logic        flush;
  logic [63:0] addr_dout;
  logic        addr_empty_n;
  logic        addr_read;
  logic [71:0] addr_din;
  logic        addr_full_n;
  logic        addr_write;
  logic [7:0]  burst_len_0_din;
  logic        burst_len_0_full_n;
  logic        burst_len_0_write;
  logic [7:0]  burst_len_1_din;
  logic        burst_len_1_full_n;
  logic        burst_len_1_write;
  logic        busy;

  typedef struct {
    logic        v;
    logic [63:0] a;
  } src_t;

  typedef struct {
    logic [63:0] a;
    logic [7:0]  l;
  } exp_t;

  src_t src_q[$];
  exp_t exp_q[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int wr_cnt   = 0;
  int both_cnt = 0;

  mmap_burst_coalescer dut (
    .clk                (clk),
    .rst                (rst),
    .max_wait_time      (max_wait_time),
    .max_burst_len      (max_burst_len),
    .flush              (flush),
    .addr_dout          (addr_dout),
    .addr_empty_n       (addr_empty_n),
    .addr_read          (addr_read),
    .addr_din           (addr_din),
    .addr_full_n        (addr_full_n),
    .addr_write         (addr_write),
    .burst_len_0_din    (burst_len_0_din),
    .burst_len_0_full_n (burst_len_0_full_n),
    .burst_len_0_write  (burst_len_0_write),
    .burst_len_1_din    (burst_len_1_din),
    .burst_len_1_full_n (burst_len_1_full_n),
    .burst_len_1_write  (burst_len_1_write),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every push is popped against the queue of expected bursts.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (addr_write || burst_len_0_write || burst_len_1_write)) begin
        wr_cnt = wr_cnt + 1;
        if (addr_read) both_cnt = both_cnt + 1;
        chk_cnt = chk_cnt + 1;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_push: got addr_din=%h with no burst expected", addr_din);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({addr_write, burst_len_0_write, burst_len_1_write} !== 3'b111 ||
              addr_din !== {e.l, e.a} || burst_len_0_din !== e.l || burst_len_1_din !== e.l) begin
            $display("FAIL push: got wr=%b%b%b addr_din=%h len0=%h len1=%h, expected wr=111 addr=%h len=%h",
                     addr_write, burst_len_0_write, burst_len_1_write, addr_din,
                     burst_len_0_din, burst_len_1_din, e.a, e.l);
          end else begin
            pass_cnt = pass_cnt + 1;
          end
        end
      end
    end
  end

  task automatic present();
    if (src_q.size() > 0 && src_q[0].v) begin
      addr_empty_n = 1'b1;
      addr_dout    = src_q[0].a;
    end else begin
      addr_empty_n = 1'b0;
      addr_dout    = 64'h0;
    end
  endtask

  // One clock: idle markers are consumed every cycle, addresses only when popped.
  task automatic step();
    logic rd;
    @(negedge clk);
    rd = addr_read;
    @(posedge clk);
    #1;
    if (src_q.size() > 0) begin
      if (!src_q[0].v || rd) void'(src_q.pop_front());
    end
    present();
  endtask

  task automatic add_beats(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) src_q.push_back('{v: 1'b1, a: base + 64'(i * 64)});
  endtask

  task automatic add_gap(input int n);
    for (int i = 0; i < n; i++) src_q.push_back('{v: 1'b0, a: 64'h0});
  endtask

  task automatic expect_burst(input logic [63:0] a, input logic [7:0] l);
    exp_q.push_back('{a: a, l: l});
  endtask

  task automatic run_idle(input string name);
    int n;
    n = 0;
    present();
    while ((src_q.size() > 0 || busy) && n < 300) begin
      step();
      n++;
    end
    chk_cnt = chk_cnt + 1;
    if (n >= 300) $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, n);
    else pass_cnt = pass_cnt + 1;
    chk_cnt = chk_cnt + 1;
    if (exp_q.size() != 0) begin
      $display("FAIL %s_missing: %0d bursts not pushed, expected 0", name, exp_q.size());
      exp_q.delete();
    end else begin
      pass_cnt = pass_cnt + 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    addr_empty_n = 1'b1;
    addr_dout = 64'h1000;
    #12;
    chk_cnt = chk_cnt + 1;
    if ({busy, addr_read, addr_write, burst_len_0_write, burst_len_1_write} !== 5'b00000)
      $display("FAIL reset_outputs: got busy/rd/wr/w0/w1=%b%b%b%b%b, expected 00000",
               busy, addr_read, addr_write, burst_len_0_write, burst_len_1_write);
    else pass_cnt = pass_cnt + 1;
    chk_cnt = chk_cnt + 1;
    if (addr_din !== 72'h0) $display("FAIL reset_din: got %h, expected 0", addr_din);
    else pass_cnt = pass_cnt + 1;
    addr_empty_n = 1'b0;
    addr_dout = 64'h0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_burst();
    max_wait_time = 4'd2;
    max_burst_len = 8'd15;
    add_beats(64'h1000, 4);
    expect_burst(64'h1000, 8'd3);
    run_idle("burst");
  endtask

  task automatic test_back_to_back();
    int b0;
    b0 = both_cnt;
    add_beats(64'h2000, 1);
    add_beats(64'h3000, 1);
    expect_burst(64'h2000, 8'd0);
    expect_burst(64'h3000, 8'd0);
    run_idle("b2b");
    chk_cnt = chk_cnt + 1;
    if (both_cnt !== b0 + 1) $display("FAIL b2b_pop_in_push: got %0d, expected 1", both_cnt - b0);
    else pass_cnt = pass_cnt + 1;
  endtask

  task automatic test_boundary();
    add_beats(64'h0F80, 4);
    expect_burst(64'h0F80, 8'd1);
    expect_burst(64'h1000, 8'd1);
    run_idle("boundary");
    add_beats(64'hFFFF_FFFF_FFFF_FFC0, 1);
    add_beats(64'h0, 1);
    expect_burst(64'hFFFF_FFFF_FFFF_FFC0, 8'd0);
    expect_burst(64'h0, 8'd0);
    run_idle("wrap");
  endtask

  task automatic test_max_len();
    add_beats(64'h0, 20);
    expect_burst(64'h0, 8'd15);
    expect_burst(64'h400, 8'd3);
    run_idle("max_len");
    max_burst_len = 8'd0;
    add_beats(64'hE000, 2);
    expect_burst(64'hE000, 8'd0);
    expect_burst(64'hE040, 8'd0);
    run_idle("len_zero");
    max_burst_len = 8'd15;
  endtask

  task automatic test_wait();
    max_wait_time = 4'd3;
    add_beats(64'h6000, 2);
    add_gap(4);
    add_beats(64'h6080, 1);
    expect_burst(64'h6000, 8'd1);
    expect_burst(64'h6080, 8'd0);
    run_idle("gap4");
    add_beats(64'h7000, 2);
    add_gap(3);
    add_beats(64'h7080, 1);
    expect_burst(64'h7000, 8'd2);
    run_idle("gap3");
    max_wait_time = 4'd0;
    add_beats(64'hA000, 1);
    add_gap(1);
    add_beats(64'hA040, 1);
    expect_burst(64'hA000, 8'd0);
    expect_burst(64'hA040, 8'd0);
    run_idle("wait_zero");
    max_wait_time = 4'd2;
  endtask

  task automatic test_flush();
    add_beats(64'hB000, 3);
    present();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    expect_burst(64'hB000, 8'd0);
    expect_burst(64'hB040, 8'd1);
    run_idle("flush");
  endtask

  task automatic test_stall();
    logic [71:0] din0;
    logic        bad_ctl;
    logic        bad_din;
    bad_ctl = 1'b0;
    bad_din = 1'b0;
    burst_len_1_full_n = 1'b0;
    add_beats(64'h5000, 1);
    add_beats(64'h9000, 1);
    present();
    step();
    step();
    #2;
    din0 = addr_din;
    for (int i = 0; i < 10; i++) begin
      if (addr_write || burst_len_0_write || burst_len_1_write || addr_read) bad_ctl = 1'b1;
      if (addr_din !== din0 || !busy) bad_din = 1'b1;
      step();
      #2;
    end
    chk_cnt = chk_cnt + 1;
    if (bad_ctl) $display("FAIL stall_ctl: got write or pop during stall, expected none");
    else pass_cnt = pass_cnt + 1;
    chk_cnt = chk_cnt + 1;
    if (bad_din || din0 !== {8'd0, 64'h5000})
      $display("FAIL stall_din: got %h (unstable=%b), expected stable %h", din0, bad_din, {8'd0, 64'h5000});
    else pass_cnt = pass_cnt + 1;
    burst_len_1_full_n = 1'b1;
    expect_burst(64'h5000, 8'd0);
    expect_burst(64'h9000, 8'd0);
    run_idle("stall");
  endtask

  task automatic test_reset_mid();
    int wc;
    max_wait_time = 4'd15;
    add_beats(64'hC000, 6);
    present();
    for (int i = 0; i < 6; i++) step();
    wc = wr_cnt;
    #2 rst = 1'b1;
    addr_empty_n = 1'b1;
    addr_dout = 64'hD000;
    #1;
    chk_cnt = chk_cnt + 1;
    if ({busy, addr_read, addr_write, burst_len_0_write, burst_len_1_write} !== 5'b00000)
      $display("FAIL mid_reset_outputs: got busy/rd/wr/w0/w1=%b%b%b%b%b, expected 00000",
               busy, addr_read, addr_write, burst_len_0_write, burst_len_1_write);
    else pass_cnt = pass_cnt + 1;
    src_q.delete();
    addr_empty_n = 1'b0;
    addr_dout = 64'h0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk_cnt = chk_cnt + 1;
    if (wr_cnt !== wc || busy !== 1'b0)
      $display("FAIL mid_reset_discard: got %0d pushes busy=%b, expected 0 pushes busy=0", wr_cnt - wc, busy);
    else pass_cnt = pass_cnt + 1;
    max_wait_time = 4'd2;
  endtask

  initial begin
    rst = 1'b1;
    max_wait_time = 4'd2;
    max_burst_len = 8'd15;
    flush = 1'b0;
    addr_dout = 64'h0;
    addr_empty_n = 1'b0;
    addr_full_n = 1'b1;
    burst_len_0_full_n = 1'b1;
    burst_len_1_full_n = 1'b1;
    test_reset();
    test_burst();
    test_back_to_back();
    test_boundary();
    test_max_len();
    test_wait();
    test_flush();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
